// File: rtl/xregf_scan.sv
// xregf_scan: register-file scan engine. Dumps an address range of a
// parallel-port register file onto a valid/ready stream, or loads it from one.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   trap              processor trap; stops exec_cycles, edge may start a dump
//   start, mode       one-cycle request (mode 0 = dump, 1 = load), IDLE only
//   busy, done        not-idle flag, one-cycle completion pulse
//   exec_cycles       saturating cycle count from reset release until trap
//   par_addr/we/in    register file address, write enable, write data
//   par_out           register file read data (RD_LAT cycles after par_addr)
//   out_data/valid/ready   dump stream
//   in_data/valid/ready    load stream
module xregf_scan #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int START_ADDR = 0,
  parameter int COUNT      = 2**ADDR_W,
  parameter int RD_LAT     = 0,
  parameter int AUTO_DUMP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] exec_cycles,
  output logic [ADDR_W-1:0] par_addr,
  output logic              par_we,
  output logic [DATA_W-1:0] par_in,
  input  logic [DATA_W-1:0] par_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int NWORDS = 1 << ADDR_W;
  localparam int LAST_I = (START_ADDR + COUNT - 1) % NWORDS;

  localparam logic [ADDR_W-1:0] FIRST =
    START_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST =
    LAST_I[ADDR_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_OUT,
    S_LOAD,
    S_WR,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic              trap_q;
  logic              trap_edge;
  logic              auto_en;
  logic              rd_lat1;
  logic              at_last;

  assign auto_en   = (AUTO_DUMP != 0);
  assign rd_lat1   = (RD_LAT != 0);
  assign trap_edge = trap & ~trap_q;
  // End test uses last, so a full 2**ADDR_W range still stops.
  assign at_last   = (cur == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur         <= FIRST;
      trap_q      <= 1'b0;
      exec_cycles <= '0;
      par_addr    <= '0;
      par_in      <= '0;
      par_we      <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      trap_q <= trap;
      if (!trap && exec_cycles != '1)
        exec_cycles <= exec_cycles + DATA_W'(1);
      done   <= 1'b0;
      par_we <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // start beats a simultaneous trap edge
          if (start) begin
            busy <= 1'b1;
            if (mode) begin
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              par_addr <= cur;
              state    <= S_RD;
            end
          end else if (auto_en && trap_edge) begin
            busy     <= 1'b1;
            par_addr <= cur;
            state    <= S_RD;
          end
        end

        S_RD: begin
          if (rd_lat1) begin
            state <= S_WAIT;
          end else begin
            out_data  <= par_out;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end

        S_WAIT: begin
          out_data  <= par_out;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (at_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cur      <= cur + ADDR_W'(1);
              par_addr <= cur + ADDR_W'(1);
              state    <= S_RD;
            end
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            par_addr <= cur;
            par_in   <= in_data;
            par_we   <= 1'b1;
            state    <= S_WR;
          end
        end

        S_WR: begin
          if (at_last) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur      <= cur + ADDR_W'(1);
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_DONE: begin
          cur   <= FIRST;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xregf_scan.sv
// tb_xregf_scan: scoreboard bench for xregf_scan.
// u0: full range, comb read. u1: wrapped range 12..1, registered read.
module tb_xregf_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic        rst0, trap0, start0, mode0;
  logic        busy0, done0, we0, ov0, ordy0, ir0, iv0;
  logic [31:0] exec0, pin0, pout0, od0, id0;
  logic [3:0]  pa0;

  logic        rst1, trap1, start1, mode1;
  logic        busy1, done1, we1, ov1, ordy1, ir1, iv1;
  logic [31:0] exec1, pin1, pout1, od1, id1;
  logic [3:0]  pa1;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic        pre0, pre1;
  logic [31:0] base0, base1;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [35:0] w1 [$];
  int          dcnt0 = 0;
  int          dcnt1 = 0;

  always @(posedge clk) begin
    if (pre0)
      for (int k = 0; k < 16; k++)
        mem0[k] <= base0 + 32'(k);
    else if (we0)
      mem0[pa0] <= pin0;
  end
  assign pout0 = mem0[pa0];

  always @(posedge clk) begin
    if (pre1)
      for (int k = 0; k < 16; k++)
        mem1[k] <= base1 + 32'(k);
    else if (we1)
      mem1[pa1] <= pin1;
    pout1 <= mem1[pa1];
  end

  xregf_scan u0 (
    .clk(clk), .rst(rst0), .trap(trap0),
    .start(start0), .mode(mode0),
    .busy(busy0), .done(done0),
    .exec_cycles(exec0),
    .par_addr(pa0), .par_we(we0),
    .par_in(pin0), .par_out(pout0),
    .out_data(od0), .out_valid(ov0),
    .out_ready(ordy0),
    .in_data(id0), .in_valid(iv0),
    .in_ready(ir0)
  );

  xregf_scan #(
    .START_ADDR(12), .COUNT(6),
    .RD_LAT(1), .AUTO_DUMP(1)
  ) u1 (
    .clk(clk), .rst(rst1), .trap(trap1),
    .start(start1), .mode(mode1),
    .busy(busy1), .done(done1),
    .exec_cycles(exec1),
    .par_addr(pa1), .par_we(we1),
    .par_in(pin1), .par_out(pout1),
    .out_data(od1), .out_valid(ov1),
    .out_ready(ordy1),
    .in_data(id1), .in_valid(iv1),
    .in_ready(ir1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  logic        stall0 = 1'b0;
  logic [31:0] held0;

  always @(negedge clk) begin
    if (stall0 && !rst0) begin
      chk("vhold0", 64'(ov0), 64'd1);
      chk("stable0", 64'(od0), 64'(held0));
    end
    if (ov0 === 1'b1 && ordy0) begin
      chk("q0_nz", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0)
        chk("out0", 64'(od0), 64'(q0.pop_front()));
    end
    stall0 = (ov0 === 1'b1) && !ordy0;
    held0  = od0;
    if (done0 === 1'b1) dcnt0++;
  end

  always @(negedge clk) begin
    if (ov1 === 1'b1 && ordy1) begin
      chk("q1_nz", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0)
        chk("out1", 64'(od1), 64'(q1.pop_front()));
    end
    if (we1 === 1'b1) begin
      chk("w1_nz", 64'(w1.size() != 0), 64'd1);
      if (w1.size() != 0)
        chk("wr1", 64'({pa1, pin1}),
            64'(w1.pop_front()));
    end
    if (done1 === 1'b1) dcnt1++;
  end

  task automatic wait_done(input int sel,
                           input int want,
                           input int lim);
    int t = 0;
    while (((sel == 0) ? dcnt0 : dcnt1) < want
           && t < lim) begin
      @(posedge clk);
      t++;
    end
    #1;
    repeat (3) @(posedge clk);
    #1;
    if (sel == 0)
      chk("done0", 64'(dcnt0), 64'(want));
    else
      chk("done1", 64'(dcnt1), 64'(want));
  endtask

  // Feeds n words into u1; rst_at > 0 resets u1
  // during the write of that word; poke pulses a
  // dump start mid-load.
  task automatic load1(input int n,
                       input logic [31:0] base,
                       input int rst_at,
                       input int poke);
    for (int k = 0; k < n; k++) begin
      logic hs = 1'b0;
      int   t  = 0;
      iv1    = 1'b1;
      id1    = base + 32'(k);
      start1 = (k == poke);
      mode1  = 1'b0;
      while (!hs && t < 20) begin
        @(negedge clk);
        hs = ir1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        t++;
      end
      chk("ld_hs", 64'(hs), 64'd1);
      iv1 = 1'b0;
      if (k + 1 == rst_at) begin
        chk("wr_pend", 64'(we1), 64'd1);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_we", 64'(we1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_ir", 64'(ir1), 64'd0);
        rst1 = 1'b0;
        return;
      end
    end
  endtask

  logic [3:0] pat;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    trap0 = 1'b0; trap1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    mode0 = 1'b0; mode1 = 1'b0;
    ordy0 = 1'b1; ordy1 = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0;
    id0 = '0; id1 = '0;
    pre0 = 1'b1; pre1 = 1'b1;
    base0 = 32'h100; base1 = 32'h200;
    pat = 4'b1001;

    repeat (3) @(posedge clk);
    #1;
    pre0 = 1'b0; pre1 = 1'b0;
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_ov0", 64'(ov0), 64'd0);
    chk("rst_we0", 64'(we0), 64'd0);
    chk("rst_exec0", 64'(exec0), 64'd0);
    chk("rst_pa0", 64'(pa0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_ir0", 64'(ir0), 64'd0);
    chk("rst_od0", 64'(od0), 64'd0);
    chk("rst_pin0", 64'(pin0), 64'd0);

    // exec count, then auto dump on trap edge
    for (int k = 0; k < 16; k++)
      q0.push_back(32'h100 + 32'(k));
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    trap0 = 1'b1;
    wait_done(0, 1, 100);
    chk("exec37", 64'(exec0), 64'd37);
    repeat (5) @(posedge clk);
    #1;
    chk("exec_frz", 64'(exec0), 64'd37);
    chk("q0_empty", 64'(q0.size()), 64'd0);

    // dump with out_ready pattern 1-0-0-1
    base0 = 32'hA0; pre0 = 1'b1;
    @(posedge clk);
    #1;
    pre0 = 1'b0;
    for (int k = 0; k < 16; k++)
      q0.push_back(32'hA0 + 32'(k));
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("lat0_e0", 64'(ov0), 64'd0);
    chk("busy0", 64'(busy0), 64'd1);
    @(posedge clk);
    #1;
    chk("lat0_e1", 64'(ov0), 64'd1);
    for (int i = 0; i < 200 && dcnt0 < 2; i++) begin
      ordy0 = pat[i % 4];
      @(posedge clk);
      #1;
    end
    ordy0 = 1'b1;
    wait_done(0, 2, 10);
    chk("q0_empty2", 64'(q0.size()), 64'd0);
    chk("idle0", 64'(busy0), 64'd0);
    chk("exec_scan", 64'(exec0), 64'd37);

    // u1: load start collides with trap edge
    for (int k = 0; k < 6; k++)
      w1.push_back({4'((12 + k) % 16), 32'(k + 1)});
    trap1 = 1'b1; start1 = 1'b1; mode1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("ld_lat", 64'(ir1), 64'd1);
    chk("busy1", 64'(busy1), 64'd1);
    load1(6, 32'd1, 0, 2);
    wait_done(1, 1, 20);
    chk("w1_empty", 64'(w1.size()), 64'd0);

    // u1: dump with registered read
    for (int k = 0; k < 6; k++)
      q1.push_back(32'(k + 1));
    mode1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("lat1_e0", 64'(ov1), 64'd0);
    @(posedge clk);
    #1;
    chk("lat1_e1", 64'(ov1), 64'd0);
    @(posedge clk);
    #1;
    chk("lat1_e2", 64'(ov1), 64'd1);
    wait_done(1, 2, 60);
    chk("q1_empty", 64'(q1.size()), 64'd0);

    // u1: reset during write of word 3, reload
    trap1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      w1.push_back({4'((12 + k) % 16),
                    32'h11 + 32'(k)});
    start1 = 1'b1; mode1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    load1(6, 32'h11, 3, -1);
    chk("w1_rst", 64'(w1.size()), 64'd0);
    for (int k = 0; k < 6; k++)
      w1.push_back({4'((12 + k) % 16),
                    32'h21 + 32'(k)});
    start1 = 1'b1; mode1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    load1(6, 32'h21, 0, -1);
    wait_done(1, 3, 20);
    chk("w1_empty2", 64'(w1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/xregf_scan.md
# xregf_scan

Parametrised register-file scan engine for the picoVersat top level. It drives the register file's parallel interface (`par_addr`, `par_we`, `par_in`, `par_out`) to dump a programmable address range onto a valid/ready output stream, or to load one from a valid/ready input stream. It also counts execution cycles from reset to `trap`, and can start a dump automatically when `trap` rises. This moves end-of-run register dumps and preloads out of the bench and into synthesizable logic.

## Interface
- `DATA_W`, 32: register and stream data width.
- `ADDR_W`, 4: register file address width.
- `START_ADDR`, 0: first address scanned.
- `COUNT`, 2**ADDR_W: words per scan, range 1..2**ADDR_W.
- `RD_LAT`, 0: register file read latency in cycles, 0 or 1.
- `AUTO_DUMP`, 1: if 1, a rising edge of `trap` starts a dump.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `trap` in 1: processor trap.
- `start` in 1: one-cycle start request, sampled in IDLE only.
- `mode` in 1: 0 = dump, 1 = load; sampled together with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a scan completes.
- `exec_cycles` out DATA_W: cycles counted from reset release until `trap`.
- `par_addr` out ADDR_W: register file address.
- `par_we` out 1: register file write enable.
- `par_in` out DATA_W: register file write data.
- `par_out` in DATA_W: register file read data.
- `out_data` out DATA_W, `out_valid` out 1, `out_ready` in 1: dump stream.
- `in_data` in DATA_W, `in_valid` in 1, `in_ready` out 1: load stream.

## Operation
- **Address range:** `cur` starts at START_ADDR. `last` = (START_ADDR+COUNT-1) mod 2**ADDR_W. Increments wrap modulo 2**ADDR_W.
- **FSM states:** IDLE, RD, WAIT, OUT, LOAD, WR, DONE.
- **IDLE:**
  - `start`&`!mode` → RD.
  - `start`&`mode` → LOAD.
  - If AUTO_DUMP, a `trap` rising edge (`trap` high, registered `trap_q` low) with no `start` → RD.
  - `start` and a trap edge in the same cycle: `start` wins and its `mode` is used.
  - In every other state, `start` and trap edges are ignored, not queued.
- **RD:** `par_addr`=`cur`.
  - RD_LAT=0: capture `par_out` into `out_data`, → OUT.
  - RD_LAT=1: → WAIT.
- **WAIT:** capture `par_out` into `out_data`, → OUT.
- **OUT:** `out_valid`=1; `out_data` stays stable until the handshake.
  - On `out_ready`: if `cur`==`last` → DONE, else `cur`+1 and → RD.
- **LOAD:** `in_ready`=1.
  - On `in_valid`: register `par_addr`=`cur`, `par_in`=`in_data`, `par_we`=1, → WR.
- **WR:** `par_we` is high for this cycle only; `in_ready`=0.
  - If `cur`==`last` → DONE, else `cur`+1 and → LOAD.
- **DONE:** `done`=1 for one cycle, `cur` reloads START_ADDR, → IDLE.
- **Idle outputs:** `par_addr` and `par_in` hold their last values; `par_we`=0.
- **exec_cycles:**
  - Cleared by `rst`.
  - Increments every cycle while `trap`=0; frozen while `trap`=1.
  - Saturates at all-ones, no wrap.
  - Unaffected by scans.
- **COUNT=2**ADDR_W:** every address is visited exactly once; the termination test compares against `last`, never against the start address.

## Timing
- **Reset values:** state IDLE, `cur`=START_ADDR, `par_addr`=0, `par_in`=0, `par_we`=0, `out_data`=0, `out_valid`=0, `in_ready`=0, `busy`=0, `done`=0, `exec_cycles`=0, `trap_q`=0.
- **Reset mid-scan:** `rst` high at any edge forces IDLE with the reset values above. A pending `par_we` is dropped and a held `out_valid` falls at that edge.
- **Dump latency:** `start` accepted at edge 0; `out_valid` first high after edge 1 (RD_LAT=0) or edge 2 (RD_LAT=1).
- **Dump throughput:** one word per 2+RD_LAT cycles with `out_ready` held high.
- **Load latency:** `in_ready` high the cycle after `start` is accepted. `par_we` is asserted the cycle after each `in_valid`&`in_ready`.
- **Load throughput:** one word per 2 cycles.
- **Completion:** `done` pulses the cycle after the final handshake or write. `busy` falls with the return to IDLE. A new `start` is accepted the cycle after `done`.
- **Backpressure:** `out_valid` must not drop without `out_ready`. `in_ready` never depends combinationally on `in_valid`.

## Test plan
- **Reset and counting:** reset, `trap` rises 37 cycles after `rst` falls → `exec_cycles`=37 and frozen; AUTO_DUMP dump emits reg0..reg15 in order, then one `done` pulse.
- **Dump with backpressure:** regs preloaded with 0xA0+k, `out_ready` toggled 1-0-0-1 → `out_data` stable while stalled; the sequence 0xA0..0xAF has no duplicates or drops.
- **Load then dump, wrapped range:** START_ADDR=12, COUNT=6, load with `in_data` 1..6 → writes go to addresses 12,13,14,15,0,1; dump returns 1..6 in the same order.
- **Read latency:** RD_LAT=1 with a registered register file → first `out_valid` 2 cycles after `start`; data matches.
- **Collisions:** `start` with `mode`=1 in the same cycle as a trap edge → load runs. `start` while `busy` → ignored, word count unchanged.
- **Reset mid-scan:** `rst` asserted during WR of word 3 → `par_we`=0 and `busy`=0 next cycle; a restarted load writes from START_ADDR.
